// File: rtl/tx_dma_req_arbiter.sv
// tx_dma_req_arbiter: round-robin share of one DMA engine request port among FLOWS tx DMA
// controllers. An in-order pending FIFO returns each engine completion to the flow that issued it.
// Latency: the request reaches OUT_DMA_REQ one cycle later through a registered grant.
//   The ACK, DONE, ADDR and DOUT paths are combinational.
// Backpressure: no new grant while the pending FIFO is full. A grant is held until ACK or withdrawal.
// Optional feature: define TX_DMA_ARB_ERR_EN to enable the sticky ERR protocol flag. Otherwise ERR is tied to 0.
module tx_dma_req_arbiter #(
  parameter int FLOWS          = 4,
  parameter int DMA_DATA_WIDTH = 64,
  parameter int MAX_PENDING    = 8,
  // A 128-bit descriptor is a single word. The address is kept 1 bit wide so the port still exists.
  localparam int AW_RAW = $clog2(128 / DMA_DATA_WIDTH),
  localparam int AW     = (AW_RAW < 1) ? 1 : AW_RAW
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [FLOWS-1:0]                  IN_DMA_REQ,
  input  logic [FLOWS*DMA_DATA_WIDTH-1:0]   IN_DMA_DOUT,
  output logic [FLOWS*AW-1:0]               IN_DMA_ADDR,
  output logic [FLOWS-1:0]                  IN_DMA_ACK,
  output logic [FLOWS-1:0]                  IN_DMA_DONE,
  output logic [FLOWS*16-1:0]               IN_DMA_TAG,
  output logic                              OUT_DMA_REQ,
  output logic [DMA_DATA_WIDTH-1:0]         OUT_DMA_DOUT,
  input  logic [AW-1:0]                     OUT_DMA_ADDR,
  input  logic                              OUT_DMA_ACK,
  input  logic                              OUT_DMA_DONE,
  input  logic [15:0]                       OUT_DMA_TAG,
  output logic                              ERR
);

  localparam int GW = $clog2(FLOWS);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PENDING);
  localparam logic [GW-1:0] LAST_RST = GW'(FLOWS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [GW-1:0] fifo_q [MAX_PENDING];

  logic [GW-1:0] rr_idx;
  logic [GW-1:0] rr_pick;
  logic          rr_vld;
  logic          in_grant;
  logic          push;
  logic          pop;
  logic [GW-1:0] head;

  assign in_grant = (state_q == ST_GRANT);
  // Only an ACK in GRANT is an accepted request. Count is below full whenever GRANT is entered.
  assign push     = in_grant && OUT_DMA_ACK;
  // A DONE with nothing outstanding has no owner and is dropped.
  assign pop      = OUT_DMA_DONE && (count_q != '0);
  assign head     = fifo_q[rd_ptr_q];

  // Round-robin search: first requester after the last served flow, wrapping modulo FLOWS.
  always_comb begin
    rr_vld  = 1'b0;
    rr_pick = last_q;
    rr_idx  = last_q;
    for (int i = 1; i <= FLOWS; i++) begin
      rr_idx = GW'((int'(last_q) + i) % FLOWS);
      if (!rr_vld && IN_DMA_REQ[rr_idx]) begin
        rr_vld  = 1'b1;
        rr_pick = rr_idx;
      end
    end
  end

  // Grant FSM: issue a grant when there is room, and hold it until ACK or withdrawal.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_vld && (count_q < FULL_CNT)) begin
          state_d = ST_GRANT;
          grant_d = rr_pick;
        end
      end
      default: begin
        // ACK wins over a withdrawal in the same cycle.
        if (OUT_DMA_ACK) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end else if (!IN_DMA_REQ[grant_q]) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Pending FIFO bookkeeping. A simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Control state registers. Reset discards any completions still outstanding.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= LAST_RST;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage holds the flow index of each accepted request. The pointers qualify it, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= grant_q;
    end
  end

  // Output muxing: the granted flow reaches the engine, and completions are routed from the FIFO head.
  always_comb begin
    OUT_DMA_REQ  = 1'b0;
    OUT_DMA_DOUT = '0;
    IN_DMA_ACK   = '0;
    IN_DMA_DONE  = '0;
    if (in_grant) begin
      OUT_DMA_REQ         = IN_DMA_REQ[grant_q];
      OUT_DMA_DOUT        = IN_DMA_DOUT[int'(grant_q) * DMA_DATA_WIDTH +: DMA_DATA_WIDTH];
      IN_DMA_ACK[grant_q] = OUT_DMA_ACK;
    end
    // The head is read before this cycle's push lands, so a same-cycle ACK cannot steal the DONE.
    if (pop) begin
      IN_DMA_DONE[head] = 1'b1;
    end
  end

  assign IN_DMA_ADDR = {FLOWS{OUT_DMA_ADDR}};
  assign IN_DMA_TAG  = {FLOWS{OUT_DMA_TAG}};

`ifdef TX_DMA_ARB_ERR_EN
  logic err_q;
  logic err_d;

  // Sticky error flag: set by an orphan DONE or by an ACK with no grant outstanding.
  always_comb begin
    err_d = err_q | (OUT_DMA_DONE && (count_q == '0)) | (OUT_DMA_ACK && !in_grant);
  end

  // Error flag register. Only reset clears it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: doc/tx_dma_req_arbiter.md
# tx_dma_req_arbiter

Round-robin arbiter that shares one DMA engine request port between FLOWS per-flow TX DMA controllers. Each controller presents a request, and the granted controller's descriptor read port (ADDR/DOUT) is muxed through to the engine. The arbiter tracks accepted requests in an in-order pending FIFO so that each engine DONE/TAG completion is returned to the flow that issued it. It sits between the per-flow tx DMA controller outputs and the shared DMA/bus-master engine.

## Interface
- FLOWS, 4, number of requesting flows (2..16)
- DMA_DATA_WIDTH, 64, descriptor word width (16, 32, 64 or 128)
- MAX_PENDING, 8, pending FIFO depth, power of two, at least 2
- AW, log2(128/DMA_DATA_WIDTH), derived, descriptor word address width (not overridable)

- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- IN_DMA_REQ  in  FLOWS  per-flow request, held until ACK
- IN_DMA_DOUT  in  FLOWS*DMA_DATA_WIDTH  per-flow descriptor words, flow i at slice i
- IN_DMA_ADDR  out  FLOWS*AW  descriptor word address, broadcast to all slices
- IN_DMA_ACK  out  FLOWS  per-flow acknowledge
- IN_DMA_DONE  out  FLOWS  per-flow completion pulse
- IN_DMA_TAG  out  FLOWS*16  completion tag, broadcast to all slices
- OUT_DMA_REQ  out  1  request to engine
- OUT_DMA_DOUT  out  DMA_DATA_WIDTH  granted flow's descriptor word
- OUT_DMA_ADDR  in  AW  engine descriptor read address
- OUT_DMA_ACK  in  1  engine accepted request
- OUT_DMA_DONE  in  1  engine completed oldest request
- OUT_DMA_TAG  in  16  tag valid with OUT_DMA_DONE
- ERR  out  1  sticky protocol error (see Configuration)

## Operation
- State machine with two states, IDLE and GRANT, plus registers grant (log2 FLOWS bits), last (last served flow), pending FIFO and count.
- IDLE → GRANT: taken when any IN_DMA_REQ is set and count < MAX_PENDING.
  - grant = first requesting flow searching last+1, last+2, … modulo FLOWS.
- In GRANT:
  - OUT_DMA_REQ = IN_DMA_REQ[grant].
  - OUT_DMA_DOUT = IN_DMA_DOUT slice grant.
  - IN_DMA_ADDR = OUT_DMA_ADDR.
  - IN_DMA_ACK[grant] = OUT_DMA_ACK. All other ACK bits are 0.
- GRANT → IDLE on OUT_DMA_ACK:
  - push grant into the FIFO.
  - last = grant.
- GRANT → IDLE on IN_DMA_REQ[grant] = 0 without ACK (request withdrawn):
  - no push; last unchanged.
- ACK in the same cycle as a withdrawn request: ACK wins, treated as accepted.
- Requests are never preempted. A grant is held until ACK or withdrawal.
- Completion handling:
  - When OUT_DMA_DONE=1 and count>0: IN_DMA_DONE[head]=1 combinationally, then pop.
  - IN_DMA_TAG = OUT_DMA_TAG on every slice, every cycle.
- Completions are assumed in order. The engine guarantees in-order DONE.
- Simultaneous push (ACK) and pop (DONE): count is unchanged, and the head is routed before the push.
- DONE with count=0, including the cycle of the first ACK: ignored, no IN_DMA_DONE; flagged per Configuration.
- FIFO full (count=MAX_PENDING): no new grant. An existing GRANT cannot reach this, since a grant is only issued when count<MAX_PENDING.
- Outside GRANT: OUT_DMA_REQ=0, all IN_DMA_ACK=0, OUT_DMA_DOUT=0.

## Timing
- Reset values: state=IDLE, last=FLOWS-1 (flow 0 is served first), count=0, FIFO pointers=0, ERR=0.
  - All outputs 0 except the pass-throughs IN_DMA_ADDR and IN_DMA_TAG.
- Request-to-engine latency: IN_DMA_REQ rising at cycle n gives OUT_DMA_REQ=1 at cycle n+1 (registered grant).
- ACK, DONE, ADDR and DOUT paths are combinational, zero latency.
- After an ACK at cycle n, the next OUT_DMA_REQ comes at n+2 at the earliest (one IDLE bubble).
- RESET asserted in any state: next cycle is IDLE with an empty FIFO. Completions outstanding before the reset are discarded.

## Configuration
- TX_DMA_ARB_ERR_EN defined:
  - ERR is set on DONE with count=0.
  - ERR is set on ACK while in IDLE.
  - ERR is cleared only by RESET.
- TX_DMA_ARB_ERR_EN undefined:
  - ERR is tied to 0.
  - Both events are silently ignored; behaviour is otherwise identical.

## Test plan
- Single request, flow 2, at cycle 5, with ACK at cycle 8:
  - OUT_DMA_REQ=1 at cycles 6–8.
  - OUT_DMA_DOUT = slice 2 while OUT_DMA_ADDR is swept 0..AW-range.
  - IN_DMA_ACK=4'b0100 at cycle 8.
  - DONE at cycle 12 gives IN_DMA_DONE=4'b0100 and IN_DMA_TAG=0x1234 on all slices.
- All four flows requesting continuously, ACK each 2 cycles after grant: grants come in order 0,1,2,3,0; DONEs return 4'b0001, 0010, 0100, 1000 in order.
- MAX_PENDING=2, flows 0 and 1 acked with no DONE, flow 3 requesting: no OUT_DMA_REQ. After one DONE (to flow 0), flow 3 is granted the next cycle.
- ACK for flow 1 and DONE for pending flow 0 in the same cycle: IN_DMA_DONE=4'b0001, count stays 1, and the next DONE goes to flow 1.
- Flow 2 withdraws its request in GRANT without ACK: return to IDLE, no FIFO push, no IN_DMA_ACK. RESET asserted mid-GRANT with 3 pending: OUT_DMA_REQ=0 the next cycle, and a following DONE is ignored.
- With TX_DMA_ARB_ERR_EN: DONE with an empty FIFO gives ERR=1 the next cycle and it stays 1 until RESET. Without the macro: ERR=0 throughout.
